// File: rtl/jtag_pkg.sv
// Shared JTAG constants: TAP state codes, instruction opcodes and
// data-register select codes. The IR block imports the same opcodes.
package jtag_pkg;

    // IEEE 1149.1 TAP state encoding
    localparam logic [3:0] TLR    = 4'hF;
    localparam logic [3:0] RTI    = 4'hC;
    localparam logic [3:0] SEL_DR = 4'h7;
    localparam logic [3:0] CAP_DR = 4'h6;
    localparam logic [3:0] SH_DR  = 4'h2;
    localparam logic [3:0] EX1_DR = 4'h1;
    localparam logic [3:0] PA_DR  = 4'h3;
    localparam logic [3:0] EX2_DR = 4'h0;
    localparam logic [3:0] UPD_DR = 4'h5;
    localparam logic [3:0] SEL_IR = 4'h4;
    localparam logic [3:0] CAP_IR = 4'hE;
    localparam logic [3:0] SH_IR  = 4'hA;
    localparam logic [3:0] EX1_IR = 4'h9;
    localparam logic [3:0] PA_IR  = 4'hB;
    localparam logic [3:0] EX2_IR = 4'h8;
    localparam logic [3:0] UPD_IR = 4'hD;

    // Instruction opcodes
    localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h0;
    localparam logic [3:0] OP_EXTEST         = 4'h1;
    localparam logic [3:0] OP_INTEST         = 4'h2;
    localparam logic [3:0] OP_RUNBIST        = 4'h3;
    localparam logic [3:0] OP_CLAMP          = 4'h4;
    localparam logic [3:0] OP_IDCODE         = 4'h5;
    localparam logic [3:0] OP_USERCODE       = 4'h6;
    localparam logic [3:0] OP_HIGHZ          = 4'h7;
    localparam logic [3:0] OP_BYPASS         = 4'hF;

    // Data-register select codes
    localparam logic [2:0] DRS_BYPASS   = 3'd0;
    localparam logic [2:0] DRS_BSR      = 3'd1;
    localparam logic [2:0] DRS_BIST     = 3'd2;
    localparam logic [2:0] DRS_IDCODE   = 3'd3;
    localparam logic [2:0] DRS_USERCODE = 3'd4;

    // Result of decoding one instruction
    typedef struct packed {
        logic [2:0] dr_sel;
        logic       mode_test;
    } instr_decode_t;

endpackage

// File: rtl/tap_controller_if.sv
// TAP controller signal bundle. The master side is the TAP controller;
// the slave side is whoever drives TMS/INSTR and consumes the strobes.
interface tap_controller_if;

    logic       TMS;
    logic [3:0] INSTR;
    logic [3:0] STATE;
    logic       TAP_RESET;
    logic       CLOCK_IR;
    logic       SHIFT_IR;
    logic       UPDATE_IR;
    logic       CLOCK_DR;
    logic       SHIFT_DR;
    logic       UPDATE_DR;
    logic       SELECT;
    logic       ENABLE;
    logic [2:0] DR_SEL;
    logic       MODE_TEST;
    logic       BIST_RUN;
    logic       BIST_DONE;

    modport master (
        input  TMS, INSTR,
        output STATE, TAP_RESET,
        output CLOCK_IR, SHIFT_IR, UPDATE_IR,
        output CLOCK_DR, SHIFT_DR, UPDATE_DR,
        output SELECT, ENABLE, DR_SEL, MODE_TEST,
        output BIST_RUN, BIST_DONE
    );

    modport slave (
        output TMS, INSTR,
        input  STATE, TAP_RESET,
        input  CLOCK_IR, SHIFT_IR, UPDATE_IR,
        input  CLOCK_DR, SHIFT_DR, UPDATE_DR,
        input  SELECT, ENABLE, DR_SEL, MODE_TEST,
        input  BIST_RUN, BIST_DONE
    );

endinterface

// File: rtl/jtag_instr_decode.sv
// Combinational instruction decode: active instruction -> DR select and
// test-mode control. While the TAP sits in Test-Logic-Reset the IDCODE
// decode is forced so the device always powers up presenting its ID.
module jtag_instr_decode
    import jtag_pkg::*;
(
    input  logic [3:0] instr,
    input  logic       tap_reset,
    output logic [2:0] dr_sel,
    output logic       mode_test
);

    instr_decode_t dec;

    // Opcode table; undefined opcodes fall back to bypass, functional mode
    always_comb begin
        dec = '{dr_sel: DRS_BYPASS, mode_test: 1'b0};
        if (tap_reset) begin
            dec = '{dr_sel: DRS_IDCODE, mode_test: 1'b0};
        end else begin
            case (instr)
                OP_BYPASS:         dec = '{dr_sel: DRS_BYPASS,   mode_test: 1'b0};
                OP_SAMPLE_PRELOAD: dec = '{dr_sel: DRS_BSR,      mode_test: 1'b0};
                OP_EXTEST:         dec = '{dr_sel: DRS_BSR,      mode_test: 1'b1};
                OP_INTEST:         dec = '{dr_sel: DRS_BSR,      mode_test: 1'b1};
                OP_RUNBIST:        dec = '{dr_sel: DRS_BIST,     mode_test: 1'b1};
                OP_CLAMP:          dec = '{dr_sel: DRS_BYPASS,   mode_test: 1'b1};
                OP_IDCODE:         dec = '{dr_sel: DRS_IDCODE,   mode_test: 1'b0};
                OP_USERCODE:       dec = '{dr_sel: DRS_USERCODE, mode_test: 1'b0};
                OP_HIGHZ:          dec = '{dr_sel: DRS_BYPASS,   mode_test: 1'b1};
                default:           dec = '{dr_sel: DRS_BYPASS,   mode_test: 1'b0};
            endcase
        end
    end

    assign dr_sel    = dec.dr_sel;
    assign mode_test = dec.mode_test;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on TCK, Moore strobe decode
// from the registered state, instruction decode and a RUNBIST cycle counter.
//
// state  | meaning
// -------+-------------------------------------------
// TLR  F | test logic reset, IDCODE forced
// RTI  C | run-test/idle, RUNBIST counts here
// SEL_DR 7 / SEL_IR 4 | column select
// CAP_x 6/E | capture into shift stage
// SH_x  2/A | shift, TDO enabled
// EX1_x 1/9, EX2_x 0/8 | exit towards pause/update
// PA_x  3/B | pause, shift stage held
// UPD_x 5/D | update strobe; UPD_IR also clears the BIST counter
module tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned BIST_CYCLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               TCK,
    input  logic               RST,
    tap_controller_if.master   tap
);

    localparam logic [CNT_W-1:0] BIST_MAX = CNT_W'(BIST_CYCLES);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic tap_reset;
    logic clock_ir, shift_ir, update_ir;
    logic clock_dr, shift_dr, update_dr;
    logic select_ir, enable;
    logic bist_run, bist_done;

    // Next-state function: TMS=0 / TMS=1 successor of every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tap.TMS ? TLR    : RTI;
            RTI:     state_d = tap.TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = tap.TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tap.TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = tap.TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tap.TMS ? UPD_DR : PA_DR;
            PA_DR:   state_d = tap.TMS ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tap.TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tap.TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = tap.TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = tap.TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = tap.TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tap.TMS ? UPD_IR : PA_IR;
            PA_IR:   state_d = tap.TMS ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tap.TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tap.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Moore strobe decode straight off the registered state
    always_comb begin
        tap_reset = (state_q == TLR);
        clock_ir  = (state_q == CAP_IR) || (state_q == SH_IR);
        shift_ir  = (state_q == SH_IR);
        update_ir = (state_q == UPD_IR);
        clock_dr  = (state_q == CAP_DR) || (state_q == SH_DR);
        shift_dr  = (state_q == SH_DR);
        update_dr = (state_q == UPD_DR);
        enable    = (state_q == SH_IR) || (state_q == SH_DR);
        case (state_q)
            SEL_IR, CAP_IR, SH_IR, EX1_IR,
            PA_IR, EX2_IR, UPD_IR: select_ir = 1'b1;
            default:               select_ir = 1'b0;
        endcase
    end

    // RUNBIST counter: counts RTI cycles, holds outside RTI, saturates.
    // The leaving edge still counts, so the budget can complete on exit.
    always_comb begin
        bist_run = (tap.INSTR == OP_RUNBIST) && (state_q == RTI);
        cnt_d    = cnt_q;
        if (tap_reset || update_ir) begin
            cnt_d = '0;
        end else if (bist_run && (cnt_q != BIST_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Mask on the clearing states so DONE drops with the strobe itself
        bist_done = (cnt_q == BIST_MAX) && !tap_reset && !update_ir;
    end

    // State and counter registers, TRST-style asynchronous reset
    always_ff @(posedge TCK or negedge RST) begin
        if (!RST) begin
            state_q <= TLR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    jtag_instr_decode u_decode (
        .instr     (tap.INSTR),
        .tap_reset (tap_reset),
        .dr_sel    (tap.DR_SEL),
        .mode_test (tap.MODE_TEST)
    );

    assign tap.STATE     = state_q;
    assign tap.TAP_RESET = tap_reset;
    assign tap.CLOCK_IR  = clock_ir;
    assign tap.SHIFT_IR  = shift_ir;
    assign tap.UPDATE_IR = update_ir;
    assign tap.CLOCK_DR  = clock_dr;
    assign tap.SHIFT_DR  = shift_dr;
    assign tap.UPDATE_DR = update_dr;
    assign tap.SELECT    = select_ir;
    assign tap.ENABLE    = enable;
    assign tap.BIST_RUN  = bist_run;
    assign tap.BIST_DONE = bist_done;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, IR/DR scans, five-ones escape,
// instruction decode sweep and the RUNBIST counter.
module tb_tap_controller;

    logic TCK;
    logic RST;
    int   n_checks;
    int   n_fail;

    tap_controller_if tap_if ();

    tap_controller #(
        .BIST_CYCLES (16),
        .CNT_W       (16)
    ) dut (
        .TCK (TCK),
        .RST (RST),
        .tap (tap_if)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // {CLOCK_IR,SHIFT_IR,UPDATE_IR,CLOCK_DR,SHIFT_DR,UPDATE_DR,SELECT,ENABLE}
    logic [7:0] strobes;
    assign strobes = {tap_if.CLOCK_IR, tap_if.SHIFT_IR, tap_if.UPDATE_IR,
                      tap_if.CLOCK_DR, tap_if.SHIFT_DR, tap_if.UPDATE_DR,
                      tap_if.SELECT, tap_if.ENABLE};

    task automatic step(input logic tms);
        @(negedge TCK);
        tap_if.TMS = tms;
        @(posedge TCK);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (tap_if.STATE !== 4'hF) begin
            n_fail++; $display("FAIL reset_state: got %h want F", tap_if.STATE);
        end
        n_checks++;
        if (strobes !== 8'h00 || tap_if.TAP_RESET !== 1'b1) begin
            n_fail++; $display("FAIL reset_strobes: got %b tr=%b want 00000000 tr=1", strobes, tap_if.TAP_RESET);
        end
        n_checks++;
        if (tap_if.DR_SEL !== 3'd3 || tap_if.MODE_TEST !== 1'b0 ||
            tap_if.BIST_RUN !== 1'b0 || tap_if.BIST_DONE !== 1'b0) begin
            n_fail++; $display("FAIL reset_decode: got dr_sel=%0d mt=%b run=%b done=%b want 3 0 0 0",
                               tap_if.DR_SEL, tap_if.MODE_TEST, tap_if.BIST_RUN, tap_if.BIST_DONE);
        end
        @(negedge TCK);
        RST = 1'b1;
        // go to SH_DR and reset mid-shift
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        n_checks++;
        if (tap_if.STATE !== 4'h2 || strobes !== 8'b0001_1001) begin
            n_fail++; $display("FAIL reset_pre_shdr: got state %h strobes %b want 2 00011001", tap_if.STATE, strobes);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (tap_if.STATE !== 4'hF || strobes !== 8'h00 || tap_if.DR_SEL !== 3'd3) begin
            n_fail++; $display("FAIL reset_async: got state %h strobes %b dr_sel %0d want F 00000000 3",
                               tap_if.STATE, strobes, tap_if.DR_SEL);
        end
        @(negedge TCK);
        tap_if.TMS = 1'b1;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_checks++;
            if (tap_if.STATE !== 4'hF || tap_if.TAP_RESET !== 1'b1) begin
                n_fail++; $display("FAIL tlr_hold[%0d]: got %h want F", i, tap_if.STATE);
            end
        end
    endtask

    task automatic test_ir_scan();
        logic       tms_v [11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        logic [3:0] st_v  [11] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
        logic [7:0] sb_v  [11] = '{8'h00, 8'h00, 8'b0000_0010, 8'b1000_0010, 8'b1100_0011,
                                   8'b1100_0011, 8'b1100_0011, 8'b1100_0011, 8'b0000_0010,
                                   8'b0010_0010, 8'h00};
        for (int i = 0; i < 11; i++) begin
            step(tms_v[i]);
            n_checks++;
            if (tap_if.STATE !== st_v[i] || strobes !== sb_v[i]) begin
                n_fail++; $display("FAIL ir_scan[%0d]: got state %h strobes %b want %h %b",
                                   i, tap_if.STATE, strobes, st_v[i], sb_v[i]);
            end
        end
    endtask

    task automatic test_dr_pause();
        logic       tms_v [10] = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 0};
        logic [3:0] st_v  [10] = '{4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
        logic [7:0] sb_v  [10] = '{8'h00, 8'b0001_0000, 8'b0001_1001, 8'h00, 8'h00, 8'h00,
                                   8'b0001_1001, 8'h00, 8'b0000_0100, 8'h00};
        for (int i = 0; i < 10; i++) begin
            step(tms_v[i]);
            n_checks++;
            if (tap_if.STATE !== st_v[i] || strobes !== sb_v[i]) begin
                n_fail++; $display("FAIL dr_scan[%0d]: got state %h strobes %b want %h %b",
                                   i, tap_if.STATE, strobes, st_v[i], sb_v[i]);
            end
        end
    endtask

    task automatic test_five_ones();
        logic [3:0] st_v  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                   4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
        int         len_v [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
        logic [7:0] path_v[16] = '{8'b0, 8'b0, 8'b01, 8'b010, 8'b0100, 8'b0101, 8'b01010,
                                   8'b010101, 8'b01011, 8'b011, 8'b0110, 8'b01100,
                                   8'b01101, 8'b011010, 8'b0110101, 8'b011011};
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int s = 0; s < 16; s++) begin
            for (int b = len_v[s] - 1; b >= 0; b--) step(path_v[s][b]);
            n_checks++;
            if (tap_if.STATE !== st_v[s]) begin
                n_fail++; $display("FAIL nav[%h]: got %h want %h", st_v[s], tap_if.STATE, st_v[s]);
            end
            for (int k = 0; k < 5; k++) step(1'b1);
            n_checks++;
            if (tap_if.STATE !== 4'hF) begin
                n_fail++; $display("FAIL escape[%h]: got %h want F", st_v[s], tap_if.STATE);
            end
        end
    endtask

    task automatic test_decode();
        logic [2:0] ds_v [16] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0,
                                  3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic       mt_v [16] = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        // park in PA_DR so the decode is not forced and BIST does not count
        step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        n_checks++;
        if (tap_if.STATE !== 4'h3) begin
            n_fail++; $display("FAIL decode_park: got %h want 3", tap_if.STATE);
        end
        for (int op = 0; op < 16; op++) begin
            @(negedge TCK);
            tap_if.INSTR = 4'(op);
            #1;
            n_checks++;
            if (tap_if.DR_SEL !== ds_v[op] || tap_if.MODE_TEST !== mt_v[op]) begin
                n_fail++; $display("FAIL decode[%h]: got %0d/%b want %0d/%b",
                                   op, tap_if.DR_SEL, tap_if.MODE_TEST, ds_v[op], mt_v[op]);
            end
        end
        @(negedge TCK);
        tap_if.INSTR = 4'h1;
        for (int k = 0; k < 5; k++) step(1'b1);
        n_checks++;
        if (tap_if.DR_SEL !== 3'd3 || tap_if.MODE_TEST !== 1'b0) begin
            n_fail++; $display("FAIL decode_tlr: got %0d/%b want 3/0", tap_if.DR_SEL, tap_if.MODE_TEST);
        end
    endtask

    task automatic test_runbist();
        // from TLR; counter is clear
        @(negedge TCK);
        tap_if.INSTR = 4'h3;
        step(1'b0);
        n_checks++;
        if (tap_if.STATE !== 4'hC || tap_if.BIST_RUN !== 1'b1 || tap_if.BIST_DONE !== 1'b0) begin
            n_fail++; $display("FAIL bist_enter: got state %h run %b done %b want C 1 0",
                               tap_if.STATE, tap_if.BIST_RUN, tap_if.BIST_DONE);
        end
        for (int i = 0; i < 9; i++) step(1'b0);  // count 9
        step(1'b1);                              // leave RTI, count 10
        n_checks++;
        if (tap_if.STATE !== 4'h7 || tap_if.BIST_RUN !== 1'b0 || tap_if.BIST_DONE !== 1'b0) begin
            n_fail++; $display("FAIL bist_leave: got state %h run %b done %b want 7 0 0",
                               tap_if.STATE, tap_if.BIST_RUN, tap_if.BIST_DONE);
        end
        step(1'b0); step(1'b1); step(1'b1); step(1'b0);  // 6,1,5,C
        for (int i = 1; i <= 9; i++) begin
            step(1'b0);
            n_checks++;
            if (tap_if.BIST_DONE !== (i >= 6)) begin
                n_fail++; $display("FAIL bist_resume[%0d]: got %b want %b", i, tap_if.BIST_DONE, (i >= 6));
            end
        end
        step(1'b1); step(1'b1); step(1'b0); step(1'b1);  // 7,4,E,9
        n_checks++;
        if (tap_if.BIST_DONE !== 1'b1) begin
            n_fail++; $display("FAIL bist_hold_ir: got %b want 1", tap_if.BIST_DONE);
        end
        step(1'b1);                                      // UPD_IR
        n_checks++;
        if (tap_if.STATE !== 4'hD || tap_if.BIST_DONE !== 1'b0) begin
            n_fail++; $display("FAIL bist_upd_ir: got state %h done %b want D 0", tap_if.STATE, tap_if.BIST_DONE);
        end
        step(1'b0);                                      // RTI, count 0
        for (int i = 0; i < 15; i++) step(1'b0);         // count 15
        n_checks++;
        if (tap_if.BIST_DONE !== 1'b0) begin
            n_fail++; $display("FAIL bist_cleared: got %b want 0", tap_if.BIST_DONE);
        end
        step(1'b1);                                      // 16th count on exit
        n_checks++;
        if (tap_if.STATE !== 4'h7 || tap_if.BIST_DONE !== 1'b1) begin
            n_fail++; $display("FAIL bist_exit_edge: got state %h done %b want 7 1", tap_if.STATE, tap_if.BIST_DONE);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST          = 1'b0;
        tap_if.TMS   = 1'b1;
        tap_if.INSTR = 4'hF;
        repeat (2) @(posedge TCK);
        #1;
        test_reset();
        test_ir_scan();
        test_dr_pause();
        test_five_ones();
        test_decode();
        test_runbist();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine that sequences the JTAG instruction and data registers.
- Advances on TMS at each rising TCK and drives the IR control strobes (CLOCK_IR, SHIFT_IR, UPDATE_IR), the matching DR strobes and the current state code.
- Decodes the active instruction into a data-register select, test-mode control and a RUNBIST cycle counter.
- Sits between the JTAG pins and the IR/DR/boundary-scan blocks.

Parameters:
- BIST_CYCLES, 16, number of Run-Test/Idle TCK cycles RUNBIST must spend before BIST_DONE asserts (1..65535).
- CNT_W, 16, width of the RUNBIST counter.

Ports:
- TCK  input  1  test clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-low reset (TRST equivalent).
- TMS  input  1  test mode select.
- INSTR  input  4  current instruction from the IR block's update stage.
- STATE  output  4  current TAP state code.
- TAP_RESET  output  1  high in Test-Logic-Reset.
- CLOCK_IR  output  1  IR shift-stage clock enable.
- SHIFT_IR  output  1  IR shift select (0 = capture).
- UPDATE_IR  output  1  IR update strobe.
- CLOCK_DR  output  1  DR shift-stage clock enable.
- SHIFT_DR  output  1  DR shift select.
- UPDATE_DR  output  1  DR update strobe.
- SELECT  output  1  TDO mux source: 1 = IR path, 0 = DR path.
- ENABLE  output  1  TDO output enable.
- DR_SEL  output  3  data-register select.
- MODE_TEST  output  1  boundary cells drive pins.
- BIST_RUN  output  1  BIST engine enable.
- BIST_DONE  output  1  RUNBIST cycle budget met.

Behaviour:
- State codes, IEEE 1149.1 encoding:
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D
- Transitions on rising TCK, written as TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PA_DR / UPD_DR
  - PA_DR: PA_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR states mirror the DR states; UPD_IR: RTI / SEL_DR.
- From any state, five consecutive TMS=1 cycles reach TLR.
- RST low asynchronously forces:
  - STATE=F, counter=0.
  - All strobes 0, ENABLE=0, TAP_RESET=1, SELECT=0.
  - DR_SEL=IDCODE select, MODE_TEST=0, BIST_RUN=0, BIST_DONE=0.
- Reset mid-shift aborts the shift with no update strobe. Release is synchronous to the next rising TCK.
- Strobes are Moore decodes of the registered STATE; zero latency relative to STATE:
  - CLOCK_IR=1 in CAP_IR, SH_IR.
  - SHIFT_IR=1 in SH_IR.
  - UPDATE_IR=1 in UPD_IR.
  - DR strobes are analogous in the DR states.
  - SELECT=1 in SEL_IR through UPD_IR (codes E,A,9,B,8,D,4).
  - ENABLE=1 in SH_IR or SH_DR only.
- Instruction decode, opcode -> DR_SEL / MODE_TEST:
  - BYPASS F -> 0 / 0
  - SAMPLE_PRELOAD 0 -> 1 (BSR) / 0
  - EXTEST 1 -> 1 / 1
  - INTEST 2 -> 1 / 1
  - RUNBIST 3 -> 2 (BIST status) / 1
  - CLAMP 4 -> 0 / 1
  - IDCODE 5 -> 3 / 0
  - USERCODE 6 -> 4 / 0
  - HIGHZ 7 -> 0 / 1
  - Any undefined opcode -> 0 / 0
  - TAP_RESET forces the IDCODE decode regardless of INSTR.
- RUNBIST counter:
  - BIST_RUN=1 when INSTR=RUNBIST and STATE=RTI.
  - Counter increments each rising TCK with BIST_RUN=1 and saturates at BIST_CYCLES.
  - BIST_DONE=1 while counter==BIST_CYCLES.
  - Leaving RTI holds the counter; it does not clear.
  - UPDATE_IR or TLR clears the counter and BIST_DONE.
  - Reaching the count exactly on the cycle of leaving RTI still sets BIST_DONE.
- MODE_TEST changes only when INSTR changes, i.e. after UPD_IR; no glitch on other states.

Decomposition:
- Shared package jtag_pkg:
  - 4-bit TAP state localparams.
  - Instruction opcodes BYPASS..HIGHZ, so the IR block uses the same constants.
  - DR_SEL codes.
- Sub-module jtag_instr_decode (combinational INSTR+TAP_RESET -> DR_SEL, MODE_TEST).
- The FSM, strobe decode and BIST counter stay in tap_controller.

Test Plan:
- Reset and TLR hold: RST=0 mid-SH_DR -> STATE=F, all strobes 0, DR_SEL=3 at once. Release, then TMS=1 for 3 cycles -> STATE stays F.
- IR scan: from TLR, TMS 0,1,1,0,0 -> STATE C,7,4,E,A. CLOCK_IR=1 at E and A, SHIFT_IR=1 and ENABLE=1 at A. Then TMS 0,0,0,1,1 -> stays A three cycles, then 9, D with UPDATE_IR=1 for exactly one cycle. Then TMS=0 -> C.
- DR scan with pause: TMS 1,0,0,1,0,1,0,1,1 from RTI -> 7,6,2,1,3,2(via 0)…. Check SELECT=0 throughout and SHIFT_DR=0 in PA_DR.
- Five-ones escape: from each of the 16 states, TMS=1 for 5 cycles -> STATE=F by cycle 5 or earlier.
- RUNBIST: INSTR=3, BIST_CYCLES=16, hold TMS=0 in RTI.
  - BIST_DONE rises after the 16th cycle and stays.
  - Leave after 10 cycles and return -> resumes at 10.
  - An IR update clears the counter.
- Decode sweep: INSTR 0..F -> DR_SEL/MODE_TEST per table; undefined opcodes 8..E -> 0/0.
